// File: rtl/avmm_rw_arbiter_2to1.sv
// Purpose: round-robin 2:1 arbiter onto a fixed-latency Avalon-MM rw slave, routing read data back by tag.
// Latency: command accepted in cycle A reaches s_* in A+1; readdatavalid follows in A+1+RD_LATENCY.
// Backpressure: losers see waitrequest and hold their command; read data has no backpressure.
module avmm_rw_arbiter_2to1 #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int BE_W       = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic [BE_W-1:0]   s_byteenable,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    logic req_0;
    logic req_1;
    logic grant_0;
    logic grant_1;
    logic last;     // id of the most recently granted requester
    logic s_id;     // id of the command currently on s_*

    // Read tags: stage 0 is loaded alongside s_read, the last stage lines up with s_readdata.
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_id;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

    // Round-robin grant: a lone requester wins, on contention the one not granted last wins.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (resetn) begin
            if (req_0 && (!req_1 || last)) begin
                grant_0 = 1'b1;
            end else if (req_1) begin
                grant_1 = 1'b1;
            end
        end
    end

    assign m0_waitrequest = req_0 & ~grant_0;
    assign m1_waitrequest = req_1 & ~grant_1;

    // Command register: strobes pulse for one cycle per grant, fields hold between grants.
    // A read+write request is issued as a write only.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            s_address    <= '0;
            s_byteenable <= '0;
            s_writedata  <= '0;
            s_id         <= 1'b0;
            last         <= 1'b1;
        end else begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            if (grant_0) begin
                s_read       <= m0_read & ~m0_write;
                s_write      <= m0_write;
                s_address    <= m0_address;
                s_byteenable <= m0_byteenable;
                s_writedata  <= m0_writedata;
                s_id         <= 1'b0;
                last         <= 1'b0;
            end else if (grant_1) begin
                s_read       <= m1_read & ~m1_write;
                s_write      <= m1_write;
                s_address    <= m1_address;
                s_byteenable <= m1_byteenable;
                s_writedata  <= m1_writedata;
                s_id         <= 1'b1;
                last         <= 1'b1;
            end
        end
    end

    // Tag shift register; reset drops every in-flight read so late slave data is ignored.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= s_read;
            tag_id[0]  <= s_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign m0_readdatavalid = tag_vld[RD_LATENCY-1] & ~tag_id[RD_LATENCY-1];
    assign m1_readdatavalid = tag_vld[RD_LATENCY-1] &  tag_id[RD_LATENCY-1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: doc/avmm_rw_arbiter_2to1.md
Name: avmm_rw_arbiter_2to1

Overview:
- Shares one Avalon-MM `rw` slave port between two requesters. The slave port is a fixed-latency port with no waitrequest and no readdatavalid, the same shape as the `avmm_0_rw` port our HLS components drive.
- Sits between two component instances, or a component plus a host/DMA master, and the single memory port.
- Grants one command per cycle with round-robin priority and forwards it registered to the slave.
- Tags in-flight reads so each fixed-latency readdata returns to the requester that issued it.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- BE_W, 8, byteenable width (DATA_W/8)
- RD_LATENCY, 2, slave cycles from s_read asserted to s_readdata valid; legal range 1..8

Ports:
- clock  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- m0_address  in  ADDR_W  requester 0 address
- m0_byteenable  in  BE_W  requester 0 byteenable
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  command not accepted this cycle
- m0_readdata  out  DATA_W  read data to requester 0
- m0_readdatavalid  out  1  m0_readdata valid
- m1_*  (same eight signals, same directions and widths)  requester 1
- s_address  out  ADDR_W  slave address
- s_byteenable  out  BE_W  slave byteenable
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_writedata  out  DATA_W  slave write data
- s_readdata  in  DATA_W  slave read data, valid RD_LATENCY cycles after s_read

Behaviour:
- Request: req_i = mi_read | mi_write. If both are set on one requester, the command is a write and the read is ignored.
- Arbitration is combinational on req_0/req_1 and pointer `last` (id of the last granted requester).
  - Only one requester requesting: it is granted.
  - Both requesting: grant the requester != last.
  - `last` updates on every grant.
- While resetn = 0, no grant is issued.
- mi_waitrequest = req_i & ~grant_i. A requester holds its command stable until waitrequest is low; the command is accepted in the cycle where it is low.
- Command register: a command accepted in cycle A appears on s_* in cycle A+1. s_read/s_write are high for exactly one cycle per accepted command. With no grant, s_read = s_write = 0 and s_address/s_byteenable/s_writedata hold their previous values.
- Throughput: one command per cycle. Two continuously requesting masters alternate 0,1,0,1.
- Read tag pipeline: a RD_LATENCY-deep shift register of {valid, id}.
  - Loaded with {1, id} when s_read is driven, {0, x} otherwise.
  - Output stage at cycle A+1+RD_LATENCY asserts m<id>_readdatavalid for one cycle.
  - m0_readdata = m1_readdata = s_readdata (combinational pass-through); consumers qualify with their own valid.
- Total read latency, accept to readdatavalid: RD_LATENCY+1 cycles. Reads return in issue order. No back-pressure on read data.
- Writes have no response.
- Reset values (asserted asynchronously, released synchronously into normal operation):
  - s_read = s_write = 0
  - s_address, s_byteenable, s_writedata = 0
  - all tag-pipeline valids = 0, so both readdatavalid = 0
  - last = 1, so m0 wins the first contention
- Reset mid-operation: in-flight reads are dropped, no readdatavalid is produced for them, and any slave data returning after reset is ignored.
- Simultaneous accept and return: a grant and a readdatavalid in the same cycle, to the same or different requester, are independent and both occur.

Test Plan:
- Single write: m0_write, address 0x100, writedata 0xDEADBEEF_00000001, byteenable 0xFF at cycle 5 -> m0_waitrequest = 0 at cycle 5; s_write = 1 with identical fields at cycle 6 only.
- Contention after reset: m0_read @0x10 and m1_read @0x20 both at cycle 3 -> m0 granted cycle 3, m1 waitrequest = 1 at cycle 3 and granted cycle 4; with RD_LATENCY=2, slave model returns 0xAA at cycle 6 and 0xBB at cycle 7 -> m0_readdatavalid with 0xAA at cycle 6, m1_readdatavalid with 0xBB at cycle 7.
- Round-robin fairness: both requesters issue 10 back-to-back reads -> grants strictly alternate (0,1,0,1,...); 20 readdatavalids, each routed to its issuer in issue order.
- Latency parameter: RD_LATENCY=5, single m1_read accepted at cycle 10 -> s_read at cycle 11, m1_readdatavalid at cycle 16 only; m0_readdatavalid stays 0 throughout.
- Reset mid-flight: three reads accepted, resetn pulsed low for 1 cycle before any return -> no readdatavalid afterwards; s_read/s_write = 0 during reset; next contention grants m0 first.
- Read+write on one requester: m1_read = m1_write = 1 -> single s_write pulse, no s_read, no readdatavalid.
